// File: rtl/display_pkg.sv
// Shared timing defaults and the per-pixel pipeline stage descriptor for the
// pixel scan-out path.
package display_pkg;

    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;
    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_BASE_ADDR = 0;

    typedef struct packed {
        logic       hsync_n;
        logic       vsync_n;
        logic       active;
        logic [1:0] byte_idx;
        logic       frame_start;
    } stage_t;

    localparam stage_t STAGE_BLANK = '{
        hsync_n:     1'b1,
        vsync_n:     1'b1,
        active:      1'b0,
        byte_idx:    2'd0,
        frame_start: 1'b0
    };

endpackage

// File: rtl/display_timing_gen.sv
// Horizontal/vertical raster counters with registered decode of sync, active
// region, fetch strobe and frame boundaries for the current counter state.
module display_timing_gen
    import display_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_enable,
    output logic   o_fetch,
    output logic   o_frame_end,
    output stage_t o_stage
);

    localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W      = $clog2(H_TOT);
    localparam int unsigned V_W      = $clog2(V_TOT);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [H_W-1:0] r_h, w_h_nxt;
    logic [V_W-1:0] r_v, w_v_nxt;
    logic           r_valid, w_valid_nxt;
    logic           w_h_last, w_v_last;
    stage_t         w_stage_nxt;
    logic           w_fetch_nxt, w_frame_end_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h         <= '0;
            r_v         <= '0;
            r_valid     <= 1'b0;
            o_stage     <= STAGE_BLANK;
            o_fetch     <= 1'b0;
            o_frame_end <= 1'b0;
        end else begin
            r_h         <= w_h_nxt;
            r_v         <= w_v_nxt;
            r_valid     <= w_valid_nxt;
            o_stage     <= w_stage_nxt;
            o_fetch     <= w_fetch_nxt;
            o_frame_end <= w_frame_end_nxt;
        end
    end

    // First enabled clock parks at (0,0); counting starts on the one after.
    always_comb begin
        w_h_last    = (32'(r_h) == H_TOT - 1);
        w_v_last    = (32'(r_v) == V_TOT - 1);
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        w_valid_nxt = i_enable;
        if (!i_enable) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
        end else if (r_valid) begin
            if (w_h_last) begin
                w_h_nxt = '0;
                w_v_nxt = w_v_last ? '0 : r_v + V_W'(1);
            end else begin
                w_h_nxt = r_h + H_W'(1);
            end
        end
    end

    always_comb begin
        w_stage_nxt     = STAGE_BLANK;
        w_fetch_nxt     = 1'b0;
        w_frame_end_nxt = 1'b0;
        if (w_valid_nxt) begin
            w_stage_nxt.active      = (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);
            w_stage_nxt.hsync_n     = !((32'(w_h_nxt) >= HS_START) && (32'(w_h_nxt) < HS_END));
            w_stage_nxt.vsync_n     = !((32'(w_v_nxt) >= VS_START) && (32'(w_v_nxt) < VS_END));
            w_stage_nxt.byte_idx    = w_h_nxt[1:0];
            w_stage_nxt.frame_start = (w_h_nxt == '0) && (w_v_nxt == '0);
            w_fetch_nxt             = w_stage_nxt.active && (w_h_nxt[1:0] == 2'b00);
            w_frame_end_nxt         = (32'(w_h_nxt) == H_TOT - 1) && (32'(w_v_nxt) == V_TOT - 1);
        end
    end

endmodule

// File: rtl/pixel_display_reader.sv
// Raster scan-out: fetches one 32-bit word per four pixels and emits
// sync/active/pixel two clocks after the counter state they describe.
module pixel_display_reader
    import display_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              pixRead,
    output logic [ADDR_W-1:0] pixAddr,
    input  logic [31:0]       pixData,
    output logic              hsync,
    output logic              vsync,
    output logic              videoOn,
    output logic [7:0]        pixelOut,
    output logic              frameStart
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    stage_t            w_stage;
    stage_t            r_s1;
    logic              w_fetch;
    logic              w_frame_end;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [31:0]       r_word;
    logic              w_s1_fetch;
    logic [31:0]       w_word_sel;
    logic [7:0]        w_pixel;

    display_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (enable),
        .o_fetch     (w_fetch),
        .o_frame_end (w_frame_end),
        .o_stage     (w_stage)
    );

    assign pixRead = w_fetch;
    assign pixAddr = r_pix_addr;

    // Word address advances after each fetch instead of multiplying line * width.
    always_ff @(posedge clk) begin
        if (reset || !enable || w_frame_end) begin
            r_pix_addr <= BASE;
        end else if (w_fetch) begin
            r_pix_addr <= r_pix_addr + ADDR_W'(1);
        end
    end

    // Byte 0 comes straight off the bus; later bytes from the held word.
    always_comb begin
        w_s1_fetch = r_s1.active && (r_s1.byte_idx == 2'd0);
        w_word_sel = w_s1_fetch ? pixData : r_word;
        w_pixel    = w_word_sel[{r_s1.byte_idx, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= STAGE_BLANK;
            r_word     <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            videoOn    <= 1'b0;
            pixelOut   <= 8'h00;
            frameStart <= 1'b0;
        end else begin
            r_s1 <= w_stage;
            if (w_s1_fetch) begin
                r_word <= pixData;
            end
            hsync      <= r_s1.hsync_n;
            vsync      <= r_s1.vsync_n;
            videoOn    <= r_s1.active;
            pixelOut   <= r_s1.active ? w_pixel : 8'h00;
            frameStart <= r_s1.frame_start;
        end
    end

endmodule

// File: tb/tb_pixel_display_reader.sv
// Bench for pixel_display_reader on a 12x5 raster: directed spec points plus
// randomized enable/reset against a run-index reference model.
module tb_pixel_display_reader;

    localparam int HA   = 8;
    localparam int HF   = 1;
    localparam int HS   = 2;
    localparam int HB   = 1;
    localparam int VA   = 2;
    localparam int VF   = 1;
    localparam int VS   = 1;
    localparam int VB   = 1;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VT   = VA + VF + VS + VB;
    localparam int WPL  = HA / 4;
    localparam int BASE = 32'h100;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        pixRead;
    logic [15:0] pixAddr;
    logic [31:0] pixData;
    logic        hsync;
    logic        vsync;
    logic        videoOn;
    logic [7:0]  pixelOut;
    logic        frameStart;

    logic [31:0] mem [16];
    int          run;
    int          hist [3];
    int          n_chk;
    int          n_pass;
    int          n_fail;

    pixel_display_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .ADDR_W (16), .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pixRead    (pixRead),
        .pixAddr    (pixAddr),
        .pixData    (pixData),
        .hsync      (hsync),
        .vsync      (vsync),
        .videoOn    (videoOn),
        .pixelOut   (pixelOut),
        .frameStart (frameStart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words fetched earlier in the current frame, given position r since restart.
    function automatic int words_before(int r);
        int h, v, n;
        h = r % HT;
        v = (r / HT) % VT;
        if (v >= VA) return VA * WPL;
        n = (h + 3) / 4;
        if (n > WPL) n = WPL;
        return v * WPL + n;
    endfunction

    function automatic logic exp_read(int r);
        int h, v;
        if (r < 0) return 1'b0;
        h = r % HT;
        v = (r / HT) % VT;
        return (h < HA) && (v < VA) && (h % 4 == 0);
    endfunction

    // {hsync, vsync, videoOn, pixel[7:0], frameStart} for position r.
    function automatic logic [11:0] exp_out(int r);
        int          h, v;
        logic        hs, vs, von, fs;
        logic [7:0]  px;
        logic [31:0] w;
        if (r < 0) return {1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        h   = r % HT;
        v   = (r / HT) % VT;
        hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        von = (h < HA) && (v < VA);
        fs  = (h == 0) && (v == 0);
        px  = 8'h00;
        if (von) begin
            w  = mem[v * WPL + h / 4];
            px = w[8 * (h % 4) +: 8];
        end
        return {hs, vs, von, px, fs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s at %0t: observed=0x%0h expected=0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [11:0] e;
        e = exp_out(hist[2]);
        chk("pixRead",    32'(pixRead),    32'(exp_read(run)));
        chk("pixAddr",    32'(pixAddr),    32'(BASE + ((run < 0) ? 0 : words_before(run))));
        chk("hsync",      32'(hsync),      32'(e[11]));
        chk("vsync",      32'(vsync),      32'(e[10]));
        chk("videoOn",    32'(videoOn),    32'(e[9]));
        chk("pixelOut",   32'(pixelOut),   32'(e[8:1]));
        chk("frameStart", 32'(frameStart), 32'(e[0]));
    endtask

    // One clock: advance the model with the inputs seen at the edge, answer
    // the previous cycle's read, then compare.
    task automatic step();
        logic        rd;
        logic [15:0] ad;
        rd = pixRead;
        ad = pixAddr;
        @(posedge clk);
        if (reset) begin
            run  = -1;
            hist = '{-1, -1, -1};
        end else begin
            run     = enable ? ((run < 0) ? 0 : run + 1) : -1;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = run;
        end
        #1;
        pixData = (rd === 1'b1) ? mem[ad[3:0]] : $urandom();
        check_all();
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        n_fail  = 0;
        run     = -1;
        hist    = '{-1, -1, -1};
        reset   = 1'b1;
        enable  = 1'b1;
        pixData = '0;
        mem[0]  = 32'h44332211;
        for (int i = 1; i < 16; i++) mem[i] = $urandom();

        repeat (3) step();
        chk("rst_addr", 32'(pixAddr), 32'h100);
        reset = 1'b0;

        // Three free-running frames from reset release.
        for (int c = 0; c < 185; c++) begin
            step();
            case (c)
                0:   begin chk("c0_rd", 32'(pixRead), 32'd1); chk("c0_addr", 32'(pixAddr), 32'h100); end
                2:   begin chk("c2_pix", 32'(pixelOut), 32'h11); chk("c2_fs", 32'(frameStart), 32'd1); end
                3:   chk("c3_pix", 32'(pixelOut), 32'h22);
                4:   begin chk("c4_pix", 32'(pixelOut), 32'h33); chk("c4_addr", 32'(pixAddr), 32'h101); end
                5:   begin chk("c5_pix", 32'(pixelOut), 32'h44); chk("c5_von", 32'(videoOn), 32'd1); end
                11:  chk("c11_hs", 32'(hsync), 32'd0);
                13:  chk("c13_hs", 32'(hsync), 32'd1);
                12:  chk("c12_addr", 32'(pixAddr), 32'h102);
                16:  chk("c16_addr", 32'(pixAddr), 32'h103);
                38:  chk("c38_vs", 32'(vsync), 32'd0);
                49:  chk("c49_vs", 32'(vsync), 32'd0);
                50:  chk("c50_vs", 32'(vsync), 32'd1);
                60:  chk("c60_addr", 32'(pixAddr), 32'h100);
                62:  chk("c62_fs", 32'(frameStart), 32'd1);
                120: chk("c120_addr", 32'(pixAddr), 32'h100);
                122: chk("c122_fs", 32'(frameStart), 32'd1);
                default: ;
            endcase
        end

        // Enable dropped during clock 6, restored later.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c <= 6; c++) step();
        enable = 1'b0;
        step();
        chk("dis_c7_rd", 32'(pixRead), 32'd0);
        step();
        chk("dis_c8_von", 32'(videoOn), 32'd1);
        step();
        chk("dis_c9_von", 32'(videoOn), 32'd0);
        chk("dis_c9_hs", 32'(hsync), 32'd1);
        repeat (3) step();
        enable = 1'b1;
        step();
        chk("reen_rd", 32'(pixRead), 32'd1);
        chk("reen_addr", 32'(pixAddr), 32'h100);

        // Reset asserted during clock 30 with enable still high.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c <= 30; c++) step();
        reset = 1'b1;
        step();
        chk("rst30_rd", 32'(pixRead), 32'd0);
        chk("rst30_addr", 32'(pixAddr), 32'h100);
        chk("rst30_vs", 32'(vsync), 32'd1);
        reset = 1'b0;

        // Randomized enable/reset traffic.
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 63) == 0);
            enable = ($urandom_range(0, 15) != 0);
            step();
        end
        reset  = 1'b0;
        enable = 1'b1;
        repeat (130) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
